// File: rtl/psum_writeback.sv
// psum_writeback: captures one row of PE-grid psums and serialises it into
// the results BRAM, one element per cycle. Optional ReLU: PSUM_WB_RELU_EN.
module psum_writeback #(
   parameter int NUM_COLS    = 14,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 6,
   parameter int ACTIVE_COLS = 14,
   parameter int NUM_ROWS    = 4,
   parameter int BASE_ADDR   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       psum_valid,
   input  logic [NUM_COLS*DATA_W-1:0] psum_outs,
   output logic                       psum_ready,
   output logic                       bram_we,
   output logic [ADDR_W-1:0]          bram_addr,
   output logic [DATA_W-1:0]          bram_din,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CW-1:0]     LAST_COL = CW'(ACTIVE_COLS - 1);
   localparam logic [RW-1:0]     LAST_ROW = RW'(NUM_ROWS - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ACTIVE_COLS);

   logic [1:0]        state;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic [DATA_W-1:0] lane_q [NUM_COLS];
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] lane_sel;
   logic [DATA_W-1:0] wr_din;
   logic              accept;
   logic              writing;

   assign psum_ready = (state == IDLE);
   assign accept     = psum_valid & psum_ready & ~clear;
   assign writing    = (state == WRITE);

   // Element address; all terms are ADDR_W wide so the sum wraps naturally.
   assign wr_addr  = BASE + ADDR_W'(row) * STRIDE + ADDR_W'(col);
   assign lane_sel = lane_q[col];

`ifdef PSUM_WB_RELU_EN
   assign wr_din = lane_sel[DATA_W-1] ? '0 : lane_sel;
`else
   assign wr_din = lane_sel;
`endif

   // Write port is live only in WRITE; otherwise it shows the last write.
   assign bram_we    = writing;
   assign bram_addr  = writing ? wr_addr : addr_q;
   assign bram_din   = writing ? wr_din : din_q;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

   // Row/column sequencer; clear aborts the frame from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else if (clear) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (psum_valid) begin
                  state <= WRITE;
                  col   <= '0;
               end
            end
            WRITE: begin
               if (col == LAST_COL) begin
                  col <= '0;
                  if (row == LAST_ROW) begin
                     state <= DONE;
                  end else begin
                     row   <= row + 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end
            DONE: begin
               row   <= '0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               row   <= '0;
               col   <= '0;
            end
         endcase
      end
   end

   // Remember the most recent write so the BRAM port holds it when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         din_q  <= '0;
      end else if (writing) begin
         addr_q <= wr_addr;
         din_q  <= wr_din;
      end
   end

   // Capture buffer keeps the row stable while upstream moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_COLS; k++) begin
            lane_q[k] <= '0;
         end
      end else if (accept) begin
         for (int k = 0; k < NUM_COLS; k++) begin
            lane_q[k] <= psum_outs[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 SHALL have parameter NUM_COLS, default 14: number of psum lanes from the PE grid.
REQ-002 SHALL have parameter DATA_W, default 16: psum and BRAM data width.
REQ-003 SHALL have parameter ADDR_W, default 6: results BRAM address width.
REQ-004 SHALL have parameter ACTIVE_COLS, default 14, range 1..NUM_COLS: lanes written per row, lanes 0..ACTIVE_COLS-1.
REQ-005 SHALL have parameter NUM_ROWS, default 4: rows per frame.
REQ-006 SHALL have parameter BASE_ADDR, default 0: BRAM address of frame element 0.
REQ-007 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port clear, input, 1: abort current frame and restart at row 0.
REQ-010 SHALL have port psum_valid, input, 1: psum_outs holds a complete row.
REQ-011 SHALL have port psum_outs, input, NUM_COLS*DATA_W: lane k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port psum_ready, output, 1: block can accept a row this cycle.
REQ-013 SHALL have port bram_we, output, 1: results BRAM write enable.
REQ-014 SHALL have port bram_addr, output, ADDR_W: results BRAM address.
REQ-015 SHALL have port bram_din, output, DATA_W: results BRAM write data.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse after the last element of the last row is written.

Function
REQ-018 SHALL implement states IDLE, WRITE and DONE.
REQ-019 In IDLE, psum_ready SHALL be 1; in WRITE and DONE it SHALL be 0.
REQ-020 On a cycle with psum_valid=1 and psum_ready=1, the block SHALL register all NUM_COLS lanes, clear col to 0 and go to WRITE.
REQ-021 In WRITE, each cycle SHALL drive bram_we=1, bram_din=lane[col] and bram_addr=(BASE_ADDR + row*ACTIVE_COLS + col) mod 2^ADDR_W, then increment col.
REQ-022 Latency SHALL be: capture at edge N, first write visible during cycle N+1, one element per cycle, ACTIVE_COLS consecutive write cycles.
REQ-023 After the write with col=ACTIVE_COLS-1, the block SHALL go to IDLE with row+1 if row<NUM_ROWS-1; otherwise it SHALL go to DONE.
REQ-024 DONE SHALL last exactly one cycle with frame_done=1, reset row to 0 and return to IDLE.
REQ-025 Outside WRITE, bram_we SHALL be 0; bram_addr and bram_din SHALL hold their last values.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W without error indication.
REQ-027 clear=1 in any state SHALL, at the next edge, set state=IDLE, row=0, col=0 and bram_we=0, and SHALL NOT assert frame_done.
REQ-028 When clear=1 and psum_valid=1 occur together, clear SHALL win and no capture SHALL occur.
REQ-029 While psum_ready=0, psum_valid SHALL be ignored; the upstream holds the row until it is accepted.
REQ-030 Captured lanes SHALL be stable through WRITE, unaffected by psum_outs changes.

Reset
REQ-031 With rst=1 at an edge: state=IDLE, row=0, col=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, frame_done=0, capture buffer=0.
REQ-032 psum_ready SHALL read 1 in the first cycle after reset deasserts; rst SHALL take priority over clear and psum_valid.
REQ-033 rst asserted mid-WRITE SHALL abort the row with no further writes.

Configuration
REQ-034 When PSUM_WB_RELU_EN is defined, each lane SHALL be treated as signed and values <0 SHALL be written as 0; without it, values SHALL be written unmodified.

Verification
REQ-035 Scenario: reset, then one row with lanes=k+1 and defaults -> 14 writes, addr 0..13, din 1..14, first write the cycle after capture.
REQ-036 Scenario: 4 rows back-to-back, psum_valid held high -> addr 0..55 contiguous, 15-cycle row cadence, frame_done once after addr 55 write.
REQ-037 Scenario: BASE_ADDR=60, ACTIVE_COLS=6 -> row 0 addr 60,61,62,63,0,1.
REQ-038 Scenario: clear asserted at the 5th write of row 2 -> writes stop next cycle, no frame_done, next row lands at addr BASE_ADDR.
REQ-039 Scenario: lane value 16'hFF00 -> written as 0 with PSUM_WB_RELU_EN, as 16'hFF00 without it.
REQ-040 Scenario: rst mid-WRITE while psum_outs changes -> bram_we=0 next cycle, all outputs at reset values, psum_ready=1 after release.
